// File: rtl/inst_fifo.sv
// inst_fifo: circular instruction queue, up to 2 pushes and 2 retires per cycle.
// Optional empty-queue forwarding of push data to the decoder slots: define INST_FIFO_BYPASS_EN.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          flush,
    input  logic [1:0]    push_req,
    input  logic [31:0]   push_inst0,
    input  logic [31:0]   push_inst1,
    input  logic [31:0]   push_pc0,
    input  logic [31:0]   push_pc1,
    input  logic [1:0]    pop_req,
    output logic          out_valid0,
    output logic          out_valid1,
    output logic [31:0]   out_inst0,
    output logic [31:0]   out_inst1,
    output logic [31:0]   out_pc0,
    output logic [31:0]   out_pc1,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_TWO  = (AW+1)'(2);

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    logic [AW-1:0] wr_ptr1;
    logic [AW-1:0] rd_ptr1;

    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    logic [1:0]    npush;
    logic [1:0]    npop;
    logic [1:0]    avail;
    logic [1:0]    nwrite;
    logic [1:0]    rd_adv;
    logic          bypass;

    logic          wr_en0;
    logic          wr_en1;
    logic [31:0]   wr_inst0;
    logic [31:0]   wr_pc0;

    // 2'b10 is illegal on both request buses and counts as no request.
    always_comb begin
        case (push_req)
            2'b01:   push_cnt = 2'd1;
            2'b11:   push_cnt = 2'd2;
            default: push_cnt = 2'd0;
        endcase
        case (pop_req)
            2'b01:   pop_cnt = 2'd1;
            2'b11:   pop_cnt = 2'd2;
            default: pop_cnt = 2'd0;
        endcase
    end

    assign full  = (count_q >= FULL_LVL);
    assign empty = (count_q == '0);
    assign count = count_q;

`ifdef INST_FIFO_BYPASS_EN
    assign bypass = empty && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign npush = full ? 2'd0 : push_cnt;

    // Retires are capped at what the decoder slots actually show this cycle.
    always_comb begin
        if (bypass)
            avail = npush;
        else if (count_q >= CNT_TWO)
            avail = 2'd2;
        else
            avail = count_q[1:0];
        npop = (pop_cnt > avail) ? avail : pop_cnt;
    end

    // Forwarded entries retired in the same cycle never reach storage.
    always_comb begin
        if (bypass) begin
            nwrite = npush - npop;
            rd_adv = 2'd0;
        end else begin
            nwrite = npush;
            rd_adv = npop;
        end
    end

    assign wr_ptr1  = wr_ptr + AW'(1);
    assign rd_ptr1  = rd_ptr + AW'(1);
    assign wr_en0   = !flush && (nwrite != 2'd0);
    assign wr_en1   = !flush && (nwrite == 2'd2);
    assign wr_inst0 = (bypass && npop == 2'd1) ? push_inst1 : push_inst0;
    assign wr_pc0   = (bypass && npop == 2'd1) ? push_pc1   : push_pc0;

    always_ff @(posedge clk) begin
        if (wr_en0) begin
            inst_mem[wr_ptr] <= wr_inst0;
            pc_mem[wr_ptr]   <= wr_pc0;
        end
        if (wr_en1) begin
            inst_mem[wr_ptr1] <= push_inst1;
            pc_mem[wr_ptr1]   <= push_pc1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(nwrite);
            rd_ptr  <= rd_ptr + AW'(rd_adv);
            count_q <= count_q + (AW+1)'(nwrite) - (AW+1)'(rd_adv);
        end
    end

    // Empty slots present a zero word so the decoder sees a NOP.
    always_comb begin
        out_valid0 = (count_q >= CNT_ONE);
        out_valid1 = (count_q >= CNT_TWO);
        out_inst0  = inst_mem[rd_ptr];
        out_inst1  = inst_mem[rd_ptr1];
        out_pc0    = pc_mem[rd_ptr];
        out_pc1    = pc_mem[rd_ptr1];
        if (bypass) begin
            out_valid0 = (push_cnt != 2'd0);
            out_valid1 = (push_cnt == 2'd2);
            out_inst0  = push_inst0;
            out_inst1  = push_inst1;
            out_pc0    = push_pc0;
            out_pc1    = push_pc1;
        end
        if (!out_valid0)
            out_inst0 = 32'h0;
        if (!out_valid1)
            out_inst1 = 32'h0;
    end

endmodule
